// File: rtl/rc_pkg.sv
// Shared definitions for the mesh route-compute block: direction one-hots,
// flit type codes, per-channel FSM states and flit field offset helpers.
package rc_pkg;

  localparam int DIRW = 5;

  // One-hot direction encoding {L,W,S,E,N}, N at the LSB; zero means unrouted.
  localparam logic [DIRW-1:0] DIR_NONE = 5'b00000;
  localparam logic [DIRW-1:0] DIR_N    = 5'b00001;
  localparam logic [DIRW-1:0] DIR_E    = 5'b00010;
  localparam logic [DIRW-1:0] DIR_S    = 5'b00100;
  localparam logic [DIRW-1:0] DIR_W    = 5'b01000;
  localparam logic [DIRW-1:0] DIR_L    = 5'b10000;

  typedef enum logic [1:0] {
    FT_HEAD   = 2'b00,
    FT_BODY   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } chan_state_e;

  // Type sits in the top two bits, dest_x directly below, dest_y below that.
  function automatic int type_lsb(input int ds);
    return ds - 2;
  endfunction

  function automatic int dest_x_lsb(input int ds, input int cw);
    return ds - 2 - cw;
  endfunction

  function automatic int dest_y_lsb(input int ds, input int cw);
    return ds - 2 - 2 * cw;
  endfunction

endpackage

// File: rtl/rc_chan.sv
// One route-compute channel: packet FSM, XY / pressure-adaptive route
// selection and a one-deep output register with valid/ready handshake.
// Build option: define RC_ADAPTIVE_EN to pick the less congested of the two
// productive directions; otherwise plain XY routing and pressure is ignored.
//
// state     | meaning
// ST_IDLE   | no packet open; head/single are routed, body/tail are errors
// ST_LOCKED | head accepted; body/tail reuse the stored direction
module rc_chan
  import rc_pkg::*;
#(
  parameter int DATASIZE = 40,
  parameter int WIDTH    = 3,
  parameter int CW       = 2,
  parameter int X_COORD  = 0,
  parameter int Y_COORD  = 0,
  parameter int MESH_X   = 4,
  parameter int MESH_Y   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATASIZE-1:0]   data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4*(WIDTH+1)-1:0] pressure_i,
  output logic [DATASIZE-1:0]   data_o,
  output logic [DIRW-1:0]       dir_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  err_o
);

  localparam int PW = WIDTH + 1;
  localparam int TL = type_lsb(DATASIZE);
  localparam int XL = dest_x_lsb(DATASIZE, CW);
  localparam int YL = dest_y_lsb(DATASIZE, CW);

  chan_state_e             state_q, state_d;
  logic [DIRW-1:0]         lock_q, lock_d;
  logic [DATASIZE-1:0]     data_q;
  logic [DIRW-1:0]         dir_q, dir_d;
  logic                    valid_q;
  logic                    err_q;
  logic                    err_set;

  flit_type_e              ftype;
  logic [CW-1:0]           dest_x, dest_y;
  logic                    accept;
  logic                    in_range;
  logic                    x_gt, x_lt, y_gt, y_lt;
  logic [DIRW-1:0]         x_dir, y_dir, route_dir;

  assign ftype  = flit_type_e'(data_i[TL +: 2]);
  assign dest_x = data_i[XL +: CW];
  assign dest_y = data_i[YL +: CW];

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;

  assign in_range = (int'(dest_x) < MESH_X) && (int'(dest_y) < MESH_Y);
  assign x_gt     = int'(dest_x) > X_COORD;
  assign x_lt     = int'(dest_x) < X_COORD;
  assign y_gt     = int'(dest_y) > Y_COORD;
  assign y_lt     = int'(dest_y) < Y_COORD;
  assign x_dir    = x_gt ? DIR_E : DIR_W;
  assign y_dir    = y_gt ? DIR_S : DIR_N;

`ifdef RC_ADAPTIVE_EN
  logic [PW-1:0] p_x, p_y;
  // Pressure of the X and Y candidates (fields ordered N,E,S,W from LSB).
  assign p_x = x_gt ? pressure_i[1*PW +: PW] : pressure_i[3*PW +: PW];
  assign p_y = y_gt ? pressure_i[2*PW +: PW] : pressure_i[0*PW +: PW];
`else
  logic unused_pressure;
  assign unused_pressure = ^pressure_i;
`endif

  // Route selection for a head/single flit; Y wins only on strictly lower pressure.
  always_comb begin
    route_dir = DIR_NONE;
    if (!in_range) begin
      route_dir = DIR_NONE;
    end else if (!(x_gt || x_lt) && !(y_gt || y_lt)) begin
      route_dir = DIR_L;
    end else if (!(y_gt || y_lt)) begin
      route_dir = x_dir;
    end else if (!(x_gt || x_lt)) begin
      route_dir = y_dir;
    end else begin
`ifdef RC_ADAPTIVE_EN
      route_dir = (p_y < p_x) ? y_dir : x_dir;
`else
      route_dir = x_dir;
`endif
    end
  end

  // Packet FSM next state, stored direction, outgoing direction and error event.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    dir_d   = DIR_NONE;
    err_set = 1'b0;
    if (accept) begin
      if (ftype == FT_HEAD || ftype == FT_SINGLE) begin
        dir_d = route_dir;
        if (state_q == ST_LOCKED) err_set = 1'b1;
        if (!in_range) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else if (ftype == FT_HEAD) begin
          state_d = ST_LOCKED;
          lock_d  = route_dir;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (state_q == ST_LOCKED) begin
        dir_d = lock_q;
        if (ftype == FT_TAIL) state_d = ST_IDLE;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  // FSM state and locked direction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      lock_q  <= DIR_NONE;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Output register: load on accept, drop valid on drain, hold while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dir_q   <= DIR_NONE;
      err_q   <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      if (accept) begin
        valid_q <= 1'b1;
        data_q  <= data_i;
        dir_q   <= dir_d;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign dir_o   = dir_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: rtl/rc_mesh.sv
// Mesh router route-compute stage: NCH independent rc_chan instances sharing
// the neighbour pressure vector. Build option RC_ADAPTIVE_EN (see rc_chan).
module rc_mesh
  import rc_pkg::*;
#(
  parameter int DATASIZE = 40,
  parameter int WIDTH    = 3,
  parameter int NCH      = 5,
  parameter int CW       = 2,
  parameter int X_COORD  = 0,
  parameter int Y_COORD  = 0,
  parameter int MESH_X   = 4,
  parameter int MESH_Y   = 4
) (
  input  logic                    rc_clk,
  input  logic                    rst,
  input  logic [NCH*DATASIZE-1:0] data_in,
  input  logic [NCH-1:0]          valid_in,
  output logic [NCH-1:0]          ready_out,
  input  logic [4*(WIDTH+1)-1:0]  pressure_in,
  output logic [NCH*DATASIZE-1:0] data_out,
  output logic [NCH*DIRW-1:0]     dir_out,
  output logic [NCH-1:0]          valid_out,
  input  logic [NCH-1:0]          ready_in,
  output logic [NCH-1:0]          err_out
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    rc_chan #(
      .DATASIZE (DATASIZE),
      .WIDTH    (WIDTH),
      .CW       (CW),
      .X_COORD  (X_COORD),
      .Y_COORD  (Y_COORD),
      .MESH_X   (MESH_X),
      .MESH_Y   (MESH_Y)
    ) u_chan (
      .clk_i      (rc_clk),
      .rst_i      (rst),
      .data_i     (data_in[i*DATASIZE +: DATASIZE]),
      .valid_i    (valid_in[i]),
      .ready_o    (ready_out[i]),
      .pressure_i (pressure_in),
      .data_o     (data_out[i*DATASIZE +: DATASIZE]),
      .dir_o      (dir_out[i*DIRW +: DIRW]),
      .valid_o    (valid_out[i]),
      .ready_i    (ready_in[i]),
      .err_o      (err_out[i])
    );
  end

endmodule

// File: tb/tb_rc_mesh.sv
// Bench for rc_mesh on a 4x4 mesh at node (1,1) with 5 channels, plus a
// single-channel 4x2 instance for the out-of-range destination case.
module tb_rc_mesh;

  localparam int DS  = 40;
  localparam int WD  = 3;
  localparam int NCH = 5;
  localparam int CW  = 2;
  localparam int MX  = 4;
  localparam int MY  = 4;
  localparam int NX  = 1;
  localparam int NY  = 1;
  localparam int PWV = 4 * (WD + 1);

`ifdef RC_ADAPTIVE_EN
  localparam bit ADAPT = 1'b1;
`else
  localparam bit ADAPT = 1'b0;
`endif

  localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH*DS-1:0]     data_in;
  logic [NCH-1:0]        valid_in;
  logic [NCH-1:0]        ready_out;
  logic [PWV-1:0]        pressure_in;
  logic [NCH*DS-1:0]     data_out;
  logic [NCH*5-1:0]      dir_out;
  logic [NCH-1:0]        valid_out;
  logic [NCH-1:0]        ready_in;
  logic [NCH-1:0]        err_out;

  logic [DS-1:0]         data_in2, data_out2;
  logic                  valid_in2, ready_out2, valid_out2, err_out2;
  logic [4:0]            dir_out2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  rc_mesh #(.DATASIZE(DS), .WIDTH(WD), .NCH(NCH), .CW(CW), .X_COORD(NX), .Y_COORD(NY),
            .MESH_X(MX), .MESH_Y(MY)) u_dut (
    .rc_clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .pressure_in(pressure_in), .data_out(data_out), .dir_out(dir_out), .valid_out(valid_out),
    .ready_in(ready_in), .err_out(err_out));

  rc_mesh #(.DATASIZE(DS), .WIDTH(WD), .NCH(1), .CW(CW), .X_COORD(NX), .Y_COORD(NY),
            .MESH_X(4), .MESH_Y(2)) u_dut2 (
    .rc_clk(clk), .rst(rst), .data_in(data_in2), .valid_in(valid_in2), .ready_out(ready_out2),
    .pressure_in(pressure_in), .data_out(data_out2), .dir_out(dir_out2), .valid_out(valid_out2),
    .ready_in(1'b1), .err_out(err_out2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DS-1:0] mk(input logic [1:0] t, input int x, input int y,
                                        input logic [31:0] pay);
    logic [DS-1:0] f;
    f = '0;
    f[39:38] = t;
    f[37:36] = x[1:0];
    f[35:34] = y[1:0];
    f[31:0]  = pay;
    return f;
  endfunction

  // Reference route: signed offsets from the node, one-hot {L,W,S,E,N}.
  function automatic logic [4:0] m_route(input int x, input int y, input logic [15:0] p);
    int ddx, ddy;
    logic [4:0] xd, yd;
    int px, py;
    ddx = x - NX;
    ddy = y - NY;
    if (x >= MX || y >= MY) return 5'b00000;
    if (ddx == 0 && ddy == 0) return 5'b10000;
    xd = (ddx > 0) ? 5'b00010 : 5'b01000;
    yd = (ddy > 0) ? 5'b00100 : 5'b00001;
    if (ddy == 0) return xd;
    if (ddx == 0) return yd;
    if (!ADAPT) return xd;
    px = (ddx > 0) ? int'(p[7:4]) : int'(p[15:12]);
    py = (ddy > 0) ? int'(p[11:8]) : int'(p[3:0]);
    return (py < px) ? yd : xd;
  endfunction

  // Behavioural model: one output slot per channel and an open-packet flag.
  bit            m_valid [NCH];
  logic [DS-1:0] m_data  [NCH];
  logic [4:0]    m_dir   [NCH];
  bit            m_err   [NCH];
  bit            m_open  [NCH];
  logic [4:0]    m_pdir  [NCH];

  always @(posedge clk) begin
    bit rdy;
    logic [DS-1:0] f;
    int t, x, y;
    logic [4:0] d;
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_valid[c] = 0; m_data[c] = '0; m_dir[c] = '0;
        m_err[c] = 0; m_open[c] = 0; m_pdir[c] = '0;
      end else begin
        rdy = !m_valid[c] || ready_in[c];
        if (valid_in[c] && rdy) begin
          f = data_in[c*DS +: DS];
          t = int'(f[39:38]);
          x = int'(f[37:36]);
          y = int'(f[35:34]);
          m_valid[c] = 1;
          m_data[c]  = f;
          if (t == 0 || t == 3) begin
            if (m_open[c]) m_err[c] = 1;
            d = m_route(x, y, pressure_in);
            m_dir[c] = d;
            if (x >= MX || y >= MY) begin
              m_err[c] = 1;
              m_open[c] = 0;
            end else begin
              m_open[c] = (t == 0);
              m_pdir[c] = d;
            end
          end else if (!m_open[c]) begin
            m_dir[c] = 5'b00000;
            m_err[c] = 1;
          end else begin
            m_dir[c] = m_pdir[c];
            if (t == 2) m_open[c] = 0;
          end
        end else if (ready_in[c]) begin
          m_valid[c] = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("ready_out[%0d]", c), 64'(ready_out[c]), 64'(!m_valid[c] || ready_in[c]));
        chk($sformatf("valid_out[%0d]", c), 64'(valid_out[c]), 64'(m_valid[c]));
        chk($sformatf("err_out[%0d]", c), 64'(err_out[c]), 64'(m_err[c]));
        if (m_valid[c]) begin
          chk($sformatf("data_out[%0d]", c), 64'(data_out[c*DS +: DS]), 64'(m_data[c]));
          chk($sformatf("dir_out[%0d]", c), 64'(dir_out[c*5 +: 5]), 64'(m_dir[c]));
        end
      end
    end
  end

  task automatic send(input int ch, input logic [DS-1:0] f);
    data_in[ch*DS +: DS] = f;
    valid_in[ch] = 1'b1;
    @(posedge clk); #1;
    valid_in[ch] = 1'b0;
  endtask

  initial begin
    logic [DS-1:0] fa, fb;
    rst = 1'b1; data_in = '0; valid_in = '0; ready_in = '1; pressure_in = '0;
    data_in2 = '0; valid_in2 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_dir", 64'(dir_out[24:0]), 64'd0);
    chk("rst_err", 64'(err_out), 64'd0);
    chk("rst_data0", 64'(data_out[39:0]), 64'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single flit east.
    send(0, mk(T_SINGLE, 3, 1, 32'h0000_0042));
    chk("single_E_valid", 64'(valid_out[0]), 64'd1);
    chk("single_E_dir", 64'(dir_out[4:0]), 64'b00010);
    @(posedge clk); #1;
    chk("single_E_drain", 64'(valid_out[0]), 64'd0);

    // Diagonal destination, pressure-dependent.
    pressure_in = 16'h0250;
    send(1, mk(T_HEAD, 3, 3, 32'h0000_0431));
    chk("diag_lowS_dir", 64'(dir_out[9:5]), ADAPT ? 64'b00100 : 64'b00010);
    pressure_in = 16'h0000;
    send(1, mk(T_TAIL, 0, 0, 32'h0000_0432));
    chk("diag_tail_dir", 64'(dir_out[9:5]), ADAPT ? 64'b00100 : 64'b00010);
    pressure_in = 16'h0330;
    send(1, mk(T_HEAD, 3, 3, 32'h0000_0433));
    chk("diag_tie_dir", 64'(dir_out[9:5]), 64'b00010);
    send(1, mk(T_TAIL, 0, 0, 32'h0000_0434));
    pressure_in = 16'h0000;

    // Head north, body, tail, then a body that must find the channel idle.
    send(2, mk(T_HEAD, 1, 0, 32'h0000_0441));
    chk("pkt_head_dir", 64'(dir_out[14:10]), 64'b00001);
    send(2, mk(T_BODY, 3, 3, 32'h0000_0442));
    chk("pkt_body_dir", 64'(dir_out[14:10]), 64'b00001);
    send(2, mk(T_TAIL, 2, 2, 32'h0000_0443));
    chk("pkt_tail_dir", 64'(dir_out[14:10]), 64'b00001);
    chk("pkt_no_err", 64'(err_out[2]), 64'd0);
    send(2, mk(T_BODY, 1, 0, 32'h0000_0444));
    chk("post_tail_body_dir", 64'(dir_out[14:10]), 64'd0);
    chk("post_tail_body_err", 64'(err_out[2]), 64'd1);

    // Back-pressure: output held, input waits, then enters on release.
    fa = mk(T_SINGLE, 2, 1, 32'h0000_0451);
    fb = mk(T_SINGLE, 0, 1, 32'h0000_0452);
    ready_in[3] = 1'b0;
    send(3, fa);
    data_in[3*DS +: DS] = fb;
    valid_in[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_ready", 64'(ready_out[3]), 64'd0);
      chk("stall_data", 64'(data_out[3*DS +: DS]), 64'(fa));
      chk("stall_dir", 64'(dir_out[19:15]), 64'b00010);
      @(posedge clk); #1;
    end
    ready_in[3] = 1'b1;
    #1;
    chk("release_ready", 64'(ready_out[3]), 64'd1);
    @(posedge clk); #1;
    valid_in[3] = 1'b0;
    chk("release_data", 64'(data_out[3*DS +: DS]), 64'(fb));
    chk("release_dir_W", 64'(dir_out[19:15]), 64'b01000);

    // Protocol error on an idle channel, sticky.
    send(4, mk(T_BODY, 2, 2, 32'h0000_0461));
    chk("idle_body_dir", 64'(dir_out[24:20]), 64'd0);
    chk("idle_body_err", 64'(err_out[4]), 64'd1);
    send(4, mk(T_SINGLE, 1, 1, 32'h0000_0462));
    chk("local_dir", 64'(dir_out[24:20]), 64'b10000);
    repeat (4) @(posedge clk);
    #1;
    chk("err_sticky", 64'(err_out[4]), 64'd1);

    // Out-of-range destination on the 4x2 instance.
    data_in2 = mk(T_SINGLE, 3, 3, 32'h0000_0471);
    valid_in2 = 1'b1;
    @(posedge clk); #1;
    valid_in2 = 1'b0;
    chk("oor_valid", 64'(valid_out2), 64'd1);
    chk("oor_dir", 64'(dir_out2), 64'd0);
    chk("oor_err", 64'(err_out2), 64'd1);
    chk("oor_data", 64'(data_out2), 64'(mk(T_SINGLE, 3, 3, 32'h0000_0471)));
    chk("oor_ready", 64'(ready_out2), 64'd1);

    // Head while locked re-routes and flags an error.
    send(1, mk(T_HEAD, 3, 1, 32'h0000_0481));
    chk("relock_head_dir", 64'(dir_out[9:5]), 64'b00010);
    send(1, mk(T_SINGLE, 1, 2, 32'h0000_0482));
    chk("relock_single_dir", 64'(dir_out[9:5]), 64'b00100);
    chk("relock_err", 64'(err_out[1]), 64'd1);

    // Reset in the middle of a packet.
    send(0, mk(T_HEAD, 1, 0, 32'h0000_0491));
    chk("mid_head_dir", 64'(dir_out[4:0]), 64'b00001);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 64'(valid_out), 64'd0);
    chk("mid_rst_err", 64'(err_out), 64'd0);
    send(0, mk(T_BODY, 1, 0, 32'h0000_0492));
    chk("mid_rst_body_dir", 64'(dir_out[4:0]), 64'd0);
    chk("mid_rst_body_err", 64'(err_out[0]), 64'd1);

    // Mixed traffic on all channels with random back-pressure and pressure.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      pressure_in = 16'($urandom);
      for (int c = 0; c < NCH; c++) begin
        valid_in[c] = ($urandom_range(0, 3) != 0);
        ready_in[c] = ($urandom_range(0, 3) != 0);
        data_in[c*DS +: DS] = mk(2'($urandom_range(0, 3)), $urandom_range(0, 3),
                                 $urandom_range(0, 3), $urandom);
      end
      @(posedge clk); #1;
    end
    valid_in = '0;
    ready_in = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_drain", 64'(valid_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
